sd_rx_pack_fifo: RTL and testbench

SD_RX_PACK_FIFO -- requirements
Module: sd_rx_pack_fifo

---
 rtl/sd_rx_pack_fifo.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_sd_rx_pack_fifo.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_rx_pack_fifo.sv
// -----------------------------------------------------------------------------
// sd_rx_pack_fifo
//
// Packs SD data-lane beats (1, 4 or 8 lanes) into WORD_W-bit words in the wclk
// domain, stores them in a dual-clock FIFO and presents them first-word-fall-
// through in the rclk domain. Gray-coded pointers cross the clock boundary
// through SYNC_STAGES-deep synchronizers.
//
// Configuration macro: SD_RX_PACK_BIG_ENDIAN_EN
//   defined   : first beat of a word lands in the most significant lanes
//   undefined : first beat lands in the least significant lanes
//
// Parameters
//   WORD_W      FIFO word width (multiple of 8)
//   ADR_W       address bits, depth = 2**ADR_W words (ADR_W >= 1)
//   SYNC_STAGES flip-flops per gray-pointer synchronizer (>= 2)
//
// Ports
//   wclk    in   write / pack clock
//   rst     in   asynchronous active-high reset, both domains
//   rclk    in   read clock, asynchronous to wclk
//   d       in   SD data lanes
//   wr      in   beat valid (wclk)
//   bus_w   in   lane mode: 00 1-bit, 01 4-bit, 10 8-bit, 11 as 01
//   flush   in   drop partial word, clear overrun (wclk)
//   rd      in   pop request (rclk)
//   q       out  head word (FWFT), don't-care while empty
//   full    out  FIFO full (wclk)
//   empty   out  FIFO empty (rclk)
//   wlevel  out  used words seen from wclk
//   rlevel  out  used words seen from rclk
//   overrun out  sticky: a completed word was dropped because FIFO was full
// -----------------------------------------------------------------------------
module sd_rx_pack_fifo #(
    parameter int WORD_W      = 32,
    parameter int ADR_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              wclk,
    input  logic              rst,
    input  logic              rclk,
    input  logic [7:0]        d,
    input  logic              wr,
    input  logic [1:0]        bus_w,
    input  logic              flush,
    input  logic              rd,
    output logic [WORD_W-1:0] q,
    output logic              full,
    output logic              empty,
    output logic [ADR_W:0]    wlevel,
    output logic [ADR_W:0]    rlevel,
    output logic              overrun
);

    localparam int PW    = ADR_W + 1;          // pointer width incl. wrap bit
    localparam int DEPTH = 2 ** ADR_W;
    localparam int BW    = $clog2(WORD_W);     // beat index width (max WORD_W beats)
    localparam int OW    = BW + 1;             // bit offset width, holds WORD_W

    localparam logic [1:0] MODE_1 = 2'b00;
    localparam logic [1:0] MODE_4 = 2'b01;
    localparam logic [1:0] MODE_8 = 2'b10;

    localparam logic [BW-1:0] LAST_1 = BW'(WORD_W - 1);
    localparam logic [BW-1:0] LAST_4 = BW'(WORD_W / 4 - 1);
    localparam logic [BW-1:0] LAST_8 = BW'(WORD_W / 8 - 1);

    // Inverting the two MSBs of the synchronized read gray pointer gives the
    // write gray value that corresponds to exactly DEPTH words outstanding.
    localparam logic [PW-1:0] FULL_FLIP = PW'(3) << (PW - 2);

    // -------------------------------------------------------------------------
    // Gray code helpers
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // -------------------------------------------------------------------------
    // Storage and state
    // -------------------------------------------------------------------------
    logic [WORD_W-1:0] r_ram [DEPTH];

    logic [PW-1:0]     r_wbin;
    logic [PW-1:0]     r_wgray;
    logic [PW-1:0]     r_rbin;
    logic [PW-1:0]     r_rgray;
    logic [PW-1:0]     r_r2w [SYNC_STAGES];  // read gray pointer into wclk
    logic [PW-1:0]     r_w2r [SYNC_STAGES];  // write gray pointer into rclk

    logic [BW-1:0]     r_beat;
    logic [WORD_W-1:0] r_pack;
    logic [1:0]        r_mode;
    logic              r_overrun;

    // -------------------------------------------------------------------------
    // Pack datapath (wclk)
    // -------------------------------------------------------------------------
    logic [1:0]        w_bus_mode;
    logic [1:0]        w_mode;
    logic [BW-1:0]     w_last_idx;
    logic [OW-1:0]     w_beat_ext;
    logic [OW-1:0]     w_lsb_off;
    logic [OW-1:0]     w_lane_w;
    logic [OW-1:0]     w_off;
    logic [7:0]        w_lane_mask;
    logic [WORD_W-1:0] w_mask;
    logic [WORD_W-1:0] w_val;
    logic [WORD_W-1:0] w_pack_next;
    logic              w_beat_go;
    logic              w_word_done;
    logic              w_full;
    logic              w_push;
    logic [PW-1:0]     w_wbin_next;

    assign w_bus_mode = (bus_w == 2'b11) ? MODE_4 : bus_w;

    // The lane mode is taken from bus_w on the first beat of a word and from
    // the latched copy on every later beat.
    assign w_mode = (r_beat == '0) ? w_bus_mode : r_mode;

    always_comb begin
        w_last_idx  = LAST_4;
        w_lane_w    = OW'(4);
        w_lane_mask = 8'h0F;
        case (w_mode)
            MODE_1: begin
                w_last_idx  = LAST_1;
                w_lane_w    = OW'(1);
                w_lane_mask = 8'h01;
            end
            MODE_8: begin
                w_last_idx  = LAST_8;
                w_lane_w    = OW'(8);
                w_lane_mask = 8'hFF;
            end
            default: begin
                w_last_idx  = LAST_4;
                w_lane_w    = OW'(4);
                w_lane_mask = 8'h0F;
            end
        endcase
    end

    assign w_beat_ext = {1'b0, r_beat};

    always_comb begin
        w_lsb_off = w_beat_ext << 2;
        case (w_mode)
            MODE_1:  w_lsb_off = w_beat_ext;
            MODE_8:  w_lsb_off = w_beat_ext << 3;
            default: w_lsb_off = w_beat_ext << 2;
        endcase
    end

`ifdef SD_RX_PACK_BIG_ENDIAN_EN
    // First beat occupies the top lanes, later beats move toward bit 0.
    assign w_off = OW'(WORD_W) - w_lane_w - w_lsb_off;
`else
    // First beat occupies the bottom lanes, later beats move toward the MSB.
    assign w_off = w_lsb_off;
`endif

    assign w_mask      = WORD_W'(w_lane_mask) << w_off;
    assign w_val       = WORD_W'(d & w_lane_mask) << w_off;
    assign w_pack_next = (r_pack & ~w_mask) | w_val;

    // flush overrides any beat presented in the same cycle.
    assign w_beat_go   = wr & ~flush;
    assign w_word_done = w_beat_go & (r_beat == w_last_idx);

    assign w_full      = (r_wgray == (r_r2w[SYNC_STAGES-1] ^ FULL_FLIP));
    assign w_push      = w_word_done & ~w_full;
    assign w_wbin_next = r_wbin + PW'(1);

    // -------------------------------------------------------------------------
    // Pack / write control (wclk)
    // -------------------------------------------------------------------------
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_wbin    <= '0;
            r_wgray   <= '0;
            r_beat    <= '0;
            r_pack    <= '0;
            r_mode    <= MODE_4;
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_beat    <= '0;
            r_pack    <= '0;
            r_overrun <= 1'b0;
        end else if (w_beat_go) begin
            if (r_beat == '0) begin
                r_mode <= w_bus_mode;
            end
            if (w_word_done) begin
                r_beat <= '0;
                r_pack <= '0;
                if (w_full) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_wbin  <= w_wbin_next;
                    r_wgray <= bin2gray(w_wbin_next);
                end
            end else begin
                r_beat <= r_beat + BW'(1);
                r_pack <= w_pack_next;
            end
        end
    end

    // The completed word, including its final beat, goes straight to RAM.
    always_ff @(posedge wclk) begin
        if (w_push) begin
            r_ram[r_wbin[ADR_W-1:0]] <= w_pack_next;
        end
    end

    // -------------------------------------------------------------------------
    // Read pointer synchronizer into wclk
    // -------------------------------------------------------------------------
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_r2w[i] <= '0;
            end
        end else begin
            r_r2w[0] <= r_rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_r2w[i] <= r_r2w[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Write pointer synchronizer into rclk
    // -------------------------------------------------------------------------
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_w2r[i] <= '0;
            end
        end else begin
            r_w2r[0] <= r_wgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_w2r[i] <= r_w2r[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read control (rclk)
    // -------------------------------------------------------------------------
    logic          w_empty;
    logic          w_pop;
    logic [PW-1:0] w_rbin_next;

    assign w_empty     = (r_rgray == r_w2r[SYNC_STAGES-1]);
    assign w_pop       = rd & ~w_empty;
    assign w_rbin_next = r_rbin + PW'(1);

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_rbin  <= '0;
            r_rgray <= '0;
        end else if (w_pop) begin
            r_rbin  <= w_rbin_next;
            r_rgray <= bin2gray(w_rbin_next);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign q       = r_ram[r_rbin[ADR_W-1:0]];
    assign full    = w_full;
    assign empty   = w_empty;
    assign overrun = r_overrun;
    assign wlevel  = r_wbin - gray2bin(r_r2w[SYNC_STAGES-1]);
    assign rlevel  = gray2bin(r_w2r[SYNC_STAGES-1]) - r_rbin;

endmodule

// File: tb/tb_sd_rx_pack_fifo.sv
// -----------------------------------------------------------------------------
// tb_sd_rx_pack_fifo
//
// Self-checking bench for sd_rx_pack_fifo (WORD_W = 32, ADR_W = 4). Expected
// words are queued as stimulus is generated; an independent reader process
// pops and compares whenever the FIFO is non-empty and reading is enabled.
// Honors SD_RX_PACK_BIG_ENDIAN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_sd_rx_pack_fifo;

    localparam int WORD_W = 32;
    localparam int ADR_W  = 4;

`ifdef SD_RX_PACK_BIG_ENDIAN_EN
    localparam logic [31:0] EXP_SEQ   = 32'h12345678;
    localparam logic [31:0] EXP_ALT   = 32'hAAAAAAAA;
    localparam logic [31:0] EXP_BYTES = 32'hAABBCCDD;
`else
    localparam logic [31:0] EXP_SEQ   = 32'h87654321;
    localparam logic [31:0] EXP_ALT   = 32'h55555555;
    localparam logic [31:0] EXP_BYTES = 32'hDDCCBBAA;
`endif

    logic              wclk  = 1'b0;
    logic              rclk  = 1'b0;
    logic              rst   = 1'b1;
    logic [7:0]        d     = 8'h00;
    logic              wr    = 1'b0;
    logic [1:0]        bus_w = 2'b01;
    logic              flush = 1'b0;
    logic              rd    = 1'b0;
    logic [WORD_W-1:0] q;
    logic              full;
    logic              empty;
    logic [ADR_W:0]    wlevel;
    logic [ADR_W:0]    rlevel;
    logic              overrun;

    sd_rx_pack_fifo #(
        .WORD_W      (WORD_W),
        .ADR_W       (ADR_W),
        .SYNC_STAGES (2)
    ) dut (
        .wclk    (wclk),
        .rst     (rst),
        .rclk    (rclk),
        .d       (d),
        .wr      (wr),
        .bus_w   (bus_w),
        .flush   (flush),
        .rd      (rd),
        .q       (q),
        .full    (full),
        .empty   (empty),
        .wlevel  (wlevel),
        .rlevel  (rlevel),
        .overrun (overrun)
    );

    always #5 wclk = ~wclk;
    always #7 rclk = ~rclk;

    int                vectors     = 0;
    int                miscompares = 0;
    logic [WORD_W-1:0] exp_q [$];
    bit                rd_en       = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: lanes per mode and word assembly from a beat list.
    function automatic int lanes_of(input logic [1:0] m);
        if (m == 2'b00) return 1;
        if (m == 2'b10) return 8;
        return 4;
    endfunction

    function automatic logic [WORD_W-1:0] model_word(input logic [7:0] beats [$], input int l);
        logic [63:0] w;
        logic [63:0] chunk;
        w = 64'd0;
        for (int i = 0; i < beats.size(); i++) begin
            chunk = 64'(beats[i]) & ((64'd1 << l) - 64'd1);
`ifdef SD_RX_PACK_BIG_ENDIAN_EN
            w = w | (chunk << (WORD_W - (i + 1) * l));
`else
            w = w | (chunk << (i * l));
`endif
        end
        return w[WORD_W-1:0];
    endfunction

    // Reader / monitor: checks the head word just before it is popped.
    initial begin
        forever begin
            @(negedge rclk);
            if (rd_en && !rst && !empty && ($urandom_range(0, 3) != 0)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", q, 64'hDEAD_0000_0000);
                end else begin
                    chk("q", q, exp_q.pop_front());
                end
                rd = 1'b1;
            end else begin
                rd = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // One wr beat; wr drops after the edge so consecutive calls are gapless.
    task automatic beat(input logic [7:0] dv, input logic [1:0] bw);
        @(negedge wclk);
        d     = dv;
        bus_w = bw;
        wr    = 1'b1;
        @(posedge wclk);
        #1;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge wclk);
            wr    = 1'b0;
            d     = 8'($urandom);
            bus_w = 2'($urandom);
        end
    endtask

    task automatic seq_word();
        for (int i = 1; i <= 8; i++) beat(8'(i), 2'b01);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        rd_en = 1'b1;
        while ((exp_q.size() != 0 || !empty) && n < 3000) begin
            @(posedge rclk);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        rd_en = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
    endtask

    initial begin
        logic [7:0]  bl [$];
        logic [31:0] v;
        logic [1:0]  m;
        int          l;
        int          n;
        bit          fell;

        // Reset state
        repeat (3) @(negedge wclk);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_rlevel", rlevel, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        idle(2);

        // 4-bit nibbles 1..8
        exp_q.push_back(EXP_SEQ);
        seq_word();
        chk("seq_wlevel", wlevel, 1);
        fell = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge rclk);
            #1;
            if (!empty) begin
                fell = 1'b1;
                break;
            end
        end
        chk("empty_fall_3rclk", fell, 1);
        chk("seq_rlevel", rlevel, 1);
        wait_drain();

        // 1-bit alternating, then 8-bit bytes
        exp_q.push_back(EXP_ALT);
        for (int i = 0; i < 32; i++) beat((i % 2 == 0) ? 8'hFF : 8'hFE, 2'b00);
        exp_q.push_back(EXP_BYTES);
        beat(8'hAA, 2'b10);
        beat(8'hBB, 2'b10);
        beat(8'hCC, 2'b10);
        beat(8'hDD, 2'b10);
        wait_drain();

        // Fill: 17 words with no reads
        for (int w = 0; w < 17; w++) begin
            v = $urandom;
            bl.delete();
            for (int i = 0; i < 8; i++) bl.push_back({4'h0, v[4*i +: 4]});
            if (w < 16) exp_q.push_back(model_word(bl, 4));
            for (int i = 0; i < 8; i++) beat(bl[i], 2'b01);
            if (w == 15) begin
                chk("full_at_16", full, 1);
                chk("wlevel_16", wlevel, 16);
                chk("no_overrun_yet", overrun, 0);
            end
        end
        chk("overrun_set", overrun, 1);
        chk("wlevel_still_16", wlevel, 16);
        wait_drain();
        chk("drained_empty", empty, 1);
        chk("drained_rlevel", rlevel, 0);
        idle(6);
        chk("drained_full", full, 0);
        chk("drained_wlevel", wlevel, 0);
        chk("overrun_sticky", overrun, 1);

        // Partial word then flush (with a wr in the same cycle)
        for (int i = 0; i < 5; i++) beat(8'h0F, 2'b01);
        @(negedge wclk);
        flush = 1'b1;
        wr    = 1'b1;
        d     = 8'h0E;
        @(posedge wclk);
        #1;
        flush = 1'b0;
        wr    = 1'b0;
        chk("flush_clears_overrun", overrun, 0);
        exp_q.push_back(EXP_SEQ);
        seq_word();
        wait_drain();
        chk("flush_overrun_stays0", overrun, 0);

        // Flush on the completing beat wins
        for (int i = 1; i <= 7; i++) beat(8'(i), 2'b01);
        @(negedge wclk);
        flush = 1'b1;
        wr    = 1'b1;
        d     = 8'h08;
        @(posedge wclk);
        #1;
        flush = 1'b0;
        wr    = 1'b0;
        idle(4);
        chk("flush_vs_done_wlevel", wlevel, 0);
        exp_q.push_back(EXP_SEQ);
        seq_word();
        wait_drain();

        // Randomized batches: random modes, mid-word bus_w noise, gaps
        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 10);
            rd_en = 1'b1;
            for (int w = 0; w < n; w++) begin
                m = 2'($urandom_range(0, 3));
                l = lanes_of(m);
                bl.delete();
                for (int i = 0; i < WORD_W / l; i++) bl.push_back(8'($urandom));
                exp_q.push_back(model_word(bl, l));
                for (int i = 0; i < bl.size(); i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    beat(bl[i], (i == 0) ? m : 2'($urandom_range(0, 3)));
                end
            end
            wait_drain();
        end

        // Reset mid-word with 3 words stored
        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 8; i++) beat(8'($urandom), 2'b01);
        end
        repeat (5) @(posedge rclk);
        #1;
        chk("pre_rst_rlevel", rlevel, 3);
        for (int i = 0; i < 3; i++) beat(8'($urandom), 2'b01);
        @(negedge wclk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_empty", empty, 1);
        chk("midrst_wlevel", wlevel, 0);
        chk("midrst_rlevel", rlevel, 0);
        chk("midrst_full", full, 0);
        repeat (2) @(negedge wclk);
        rst = 1'b0;
        idle(2);
        exp_q.push_back(EXP_SEQ);
        seq_word();
        chk("postrst_wlevel", wlevel, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
